// File: rtl/input_cond_pkg.sv
// input_cond_pkg: constants shared by the input conditioner and its benches.
// Optional macro INPUT_CONDITIONER_SYNC3_EN selects a 3-flop synchroniser
// instead of the default 2-flop chain.
package input_cond_pkg;

  // 20 ms of CLOCK_50 cycles: the production debounce window.
  localparam int DEBOUNCE_20MS_50MHZ = 1000000;

  // Short window so benches reach a stable level in a handful of cycles.
  localparam int DEBOUNCE_SIM = 4;

  // Depth of the metastability synchroniser in front of each debouncer.
`ifdef INPUT_CONDITIONER_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // Counter width needed to hold 0 .. cycles without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one conditioned input bit. Synchronises the raw level,
// requires DEBOUNCE_CYCLES consecutive disagreeing samples before the clean
// level follows, and emits registered one-cycle rise/fall pulses coincident
// with each level change.
// Synchroniser depth comes from input_cond_pkg::SYNC_STAGES, which is 3 when
// INPUT_CONDITIONER_SYNC3_EN is defined and 2 otherwise.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM  // legal range 1 .. 2^26-1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic                   differs;
  logic                   done;

  // The last stage of the chain is the only one the debounce logic may look at.
  assign sync    = sync_chain[SYNC_STAGES-1];
  assign differs = (sync != level);
  // The current edge is the final qualifying sample of a level change.
  assign done    = differs && (cnt == CNT_LAST);

  // Plain flop-to-flop synchroniser: raw enters at bit 0, no logic in between.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive disagreeing samples; any agreement or a completed change restarts it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!differs || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Update the clean level and fire the matching edge pulse in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= done && sync;
      fall <= done && !sync;
      if (done) begin
        level <= sync;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: board front end that turns raw asynchronous SW/KEY
// levels into clean, debounced levels plus one-cycle rise/fall strobes for
// the rate-divider/counter stage. Every bit is handled independently in the
// CLOCK_50 domain.
// Define INPUT_CONDITIONER_SYNC3_EN for a 3-flop synchroniser (one extra
// cycle of latency); the default build uses a 2-flop synchroniser.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ  // legal range 1 .. 2^26-1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // One self-contained debouncer per input bit; bits never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .level  (level_out[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner
// with WIDTH=4 and DEBOUNCE_CYCLES=4. Inputs change and outputs are sampled
// on the falling clock edge. Expected timing tracks INPUT_CONDITIONER_SYNC3_EN.
module tb_input_conditioner;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
`ifdef INPUT_CONDITIONER_SYNC3_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = DEB + 2;
`endif

  logic             clock;
  logic             reset_n;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  int check_count = 0;
  int pass_count  = 0;

  input_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want sequence complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset with all inputs high, then release with inputs low: nothing moves.
  task automatic test_reset();
    reset_n = 1'b0;
    raw_in  = 4'hF;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clock);
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== 12'h000)
        $display("[TB] FAIL reset n=%0d: got l=%b r=%b f=%b, want all 0",
                 n, level_out, rise_pulse, fall_pulse);
      else pass_count++;
    end
    raw_in  = 4'h0;
    reset_n = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== 12'h000)
        $display("[TB] FAIL reset_idle n=%0d: got l=%b r=%b f=%b, want all 0",
                 n, level_out, rise_pulse, fall_pulse);
      else pass_count++;
    end
  endtask

  // Bit 0 rises and holds, then falls: level and one-cycle pulse at n=LAT.
  task automatic test_clean_rise();
    logic [WIDTH-1:0] el, er, ef;
    raw_in = 4'b0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0001 : 4'b0000;
      er = (n == LAT) ? 4'b0001 : 4'b0000;
      ef = 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL clean_rise n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
    raw_in = 4'b0000;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0000 : 4'b0001;
      er = 4'b0000;
      ef = (n == LAT) ? 4'b0001 : 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL clean_fall n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
  endtask

  // Bit 1 high for h cycles then low. Short bursts are swallowed; long ones
  // rise at n=LAT and fall h cycles later.
  task automatic test_glitch(input int h);
    logic [WIDTH-1:0] el, er, ef;
    bit qualifies;
    qualifies = (h >= DEB);
    raw_in = 4'b0010;
    for (int n = 1; n <= h + LAT + 2; n++) begin
      @(negedge clock);
      el = (qualifies && n >= LAT && n < h + LAT) ? 4'b0010 : 4'b0000;
      er = (qualifies && n == LAT)     ? 4'b0010 : 4'b0000;
      ef = (qualifies && n == h + LAT) ? 4'b0010 : 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL glitch_h%0d n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 h, n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
      if (n == h) raw_in = 4'b0000;
    end
  endtask

  // Bit 2 toggles every 2 cycles for 20 cycles, then holds high: one rise only.
  task automatic test_bounce_train();
    logic [WIDTH-1:0] el, er, ef;
    for (int n = 0; n < 20; n++) begin
      raw_in = ((n / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== 12'h000)
        $display("[TB] FAIL bounce n=%0d: got l=%b r=%b f=%b, want all 0",
                 n, level_out, rise_pulse, fall_pulse);
      else pass_count++;
    end
    raw_in = 4'b0100;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0100 : 4'b0000;
      er = (n == LAT) ? 4'b0100 : 4'b0000;
      ef = 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL bounce_settle n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
    raw_in = 4'b0000;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0000 : 4'b0100;
      er = 4'b0000;
      ef = (n == LAT) ? 4'b0100 : 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL bounce_release n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
  endtask

  // Bit 3 goes high; a one-cycle reset on the 3rd cycle restarts qualification.
  task automatic test_reset_mid_count();
    logic [WIDTH-1:0] el, er, ef;
    raw_in = 4'b1000;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_count++;
    if ({level_out, rise_pulse, fall_pulse} !== 12'h000)
      $display("[TB] FAIL midreset_hold: got l=%b r=%b f=%b, want all 0",
               level_out, rise_pulse, fall_pulse);
    else pass_count++;
    reset_n = 1'b1;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b1000 : 4'b0000;
      er = (n == LAT) ? 4'b1000 : 4'b0000;
      ef = 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL midreset n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
    raw_in = 4'b0000;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0000 : 4'b1000;
      er = 4'b0000;
      ef = (n == LAT) ? 4'b1000 : 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL midreset_fall n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
  endtask

  // Several bits change together and pulse together, independently.
  task automatic test_simultaneous();
    logic [WIDTH-1:0] el, er, ef;
    raw_in = 4'b1011;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b1011 : 4'b0000;
      er = (n == LAT) ? 4'b1011 : 4'b0000;
      ef = 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL simul_rise n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
    raw_in = 4'b0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      el = (n >= LAT) ? 4'b0001 : 4'b1011;
      er = 4'b0000;
      ef = (n == LAT) ? 4'b1010 : 4'b0000;
      check_count++;
      if ({level_out, rise_pulse, fall_pulse} !== {el, er, ef})
        $display("[TB] FAIL simul_fall n=%0d: got l=%b r=%b f=%b, want l=%b r=%b f=%b",
                 n, level_out, rise_pulse, fall_pulse, el, er, ef);
      else pass_count++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset_n = 1'b0;
    raw_in  = 4'h0;
    $display("[TB] input_conditioner bench, DEB=%0d latency=%0d", DEB, LAT);
    test_reset();
    test_clean_rise();
    test_glitch(3);
    test_glitch(5);
    test_bounce_train();
    test_reset_mid_count();
    test_simultaneous();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
